button_debounce: RTL and testbench

Conditions the raw, asynchronous push-button input in front of the RGB sequencer FSM. It synchronises the pin, debounces it with a small state machine, and emits a clean level plus single-cycle press, release and long-press pulses. `press_pulse` drives the sequencer's `button` input directly.

---
 rtl/button_pkg.sv | 12 +
 rtl/bit_sync.sv | 34 +++
 rtl/button_debounce.sv | 138 +++++++++++++
 tb/tb_button_debounce.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types for the push-button conditioning logic.
package button_pkg;

  // Debounce FSM states: idle, qualifying a press, held, qualifying a release.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_e;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_stages_check
    $error("bit_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Each stage samples the previous one; stage 0 samples the raw pin.
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) chain_reg[gi] <= 1'b0;
        else       chain_reg[gi] <= d;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (reset) chain_reg[gi] <= 1'b0;
        else       chain_reg[gi] <= chain_reg[gi-1];
      end
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit a clean level
// plus single-cycle press, release and long-press pulses.
module button_debounce
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("button_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_deb_check
    $error("button_debounce: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_long_check
    $error("button_debounce: LONG_PRESS_CYCLES must be at least 1");
  end

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HC_W  = $clog2(LONG_PRESS_CYCLES + 1);
  // The entry cycle counts as the first stable cycle, so the counter stops
  // two short of the full window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(LONG_PRESS_CYCLES);
  localparam logic [HC_W-1:0]  HC_PRE   = HC_W'(LONG_PRESS_CYCLES - 1);

  logic s;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (button_raw),
    .q    (s)
  );

  debounce_state_e  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [HC_W-1:0]  hc_reg, hc_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             long_reg, long_next;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hc_reg      <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hc_reg      <= hc_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hc_next      = hc_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          press_next = 1'b1;
          hc_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (hc_reg != HC_MAX) hc_next = hc_reg + HC_W'(1);
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (hc_reg == HC_PRE) begin
          // Only fire while staying in PRESSED so the pulse never lands
          // in a release-qualification cycle.
          long_next = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        hc_next    = '0;
      end
    endcase
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  assign button_level  = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_press    = long_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Directed testbench for button_debounce with a run-length reference model.
module tb_button_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LONG = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_raw = 1'b0;
  logic button_level, press_pulse, release_pulse, long_press;

  button_debounce #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_raw   (button_raw),
    .button_level (button_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: accepted level plus run length of disagreeing samples.
  bit sp [SYNC];
  bit ml, m_press, m_rel, m_long;
  int rc, h;

  // Observed pulse history.
  int n_press = 0, n_rel = 0, n_long = 0;
  int press_cyc = -1, rel_cyc = -1, long_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit s_now;
    bit was_held;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) sp[i] = 1'b0;
      ml = 0; rc = 0; h = 0;
      m_press = 0; m_rel = 0; m_long = 0;
    end else begin
      s_now = sp[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) sp[i] = sp[i-1];
      sp[0] = button_raw;
      m_press = 0; m_rel = 0; m_long = 0;
      was_held = ml && (rc == 0);
      if (s_now != ml) begin
        rc++;
        if (rc == DEB) begin
          ml = s_now;
          rc = 0;
          if (ml) begin
            m_press = 1;
            h = 0;
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        rc = 0;
      end
      if (was_held && h < LONG) begin
        h++;
        if (h == LONG && s_now) m_long = 1;
      end
    end
  endtask

  // Advance the model at every active edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
    end
  end

  // Compare DUT outputs with the model on every cycle and log pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("button_level", int'(button_level), int'(ml));
        chk("press_pulse", int'(press_pulse), int'(m_press));
        chk("release_pulse", int'(release_pulse), int'(m_rel));
        chk("long_press", int'(long_press), int'(m_long));
        if (press_pulse) begin n_press++; press_cyc = cyc; end
        if (release_pulse) begin n_rel++; rel_cyc = cyc; end
        if (long_press) begin n_long++; long_cyc = cyc; end
      end
    end
  end

  task automatic set_raw(input bit v, input int n);
    button_raw = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e0, r_edge, bp, br, bl;
    reset = 1'b1;
    button_raw = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(button_level), 0);
    chk("reset_pulses", int'(press_pulse) + int'(release_pulse) + int'(long_press), 0);
    $display("phase reset: level=%0d", button_level);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Glitch shorter than the debounce window.
    bp = n_press; br = n_rel; bl = n_long;
    set_raw(1'b1, 10);
    set_raw(1'b0, 40);
    chk("glitch_press", n_press - bp, 0);
    chk("glitch_release", n_rel - br, 0);
    chk("glitch_long", n_long - bl, 0);
    $display("phase glitch: presses=%0d", n_press - bp);

    // Clean press, held past the long-press point.
    bp = n_press; bl = n_long;
    e0 = cyc + 1;
    set_raw(1'b1, 17 + 64 + 40);
    chk("clean_press_count", n_press - bp, 1);
    chk("clean_press_latency", press_cyc - e0, 17);
    chk("clean_long_delay", long_cyc - press_cyc, 64);
    chk("clean_long_count", n_long - bl, 1);
    chk("clean_level", int'(button_level), 1);
    $display("phase clean_press: press_edge=%0d long_edge=%0d", press_cyc, long_cyc);

    // Clean release.
    br = n_rel;
    e0 = cyc + 1;
    set_raw(1'b0, 40);
    chk("clean_release_count", n_rel - br, 1);
    chk("clean_release_latency", rel_cyc - e0, 17);
    chk("release_level", int'(button_level), 0);
    $display("phase clean_release: release_edge=%0d", rel_cyc);

    // Bouncy press, then a rejected release bounce at hold count 20.
    bp = n_press; br = n_rel; bl = n_long;
    set_raw(1'b1, 3);
    set_raw(1'b0, 3);
    set_raw(1'b1, 3);
    set_raw(1'b0, 3);
    e0 = cyc + 1;
    set_raw(1'b1, 17 + 20 + 1);
    chk("bounce_press_count", n_press - bp, 1);
    chk("bounce_press_latency", press_cyc - e0, 17);
    set_raw(1'b0, 5);
    set_raw(1'b1, 100);
    chk("bounce_no_release", n_rel - br, 0);
    chk("bounce_level", int'(button_level), 1);
    chk("bounce_long_delay", long_cyc - press_cyc, 69);
    chk("bounce_long_count", n_long - bl, 1);
    $display("phase bounce: press_edge=%0d long_edge=%0d", press_cyc, long_cyc);
    set_raw(1'b0, 40);

    // Reset while held at hold count 30.
    bp = n_press; br = n_rel; bl = n_long;
    e0 = cyc + 1;
    set_raw(1'b1, 17 + 30 + 1);
    chk("pre_reset_press_latency", press_cyc - e0, 17);
    reset = 1'b1;
    @(negedge clk);
    r_edge = cyc;
    chk("midreset_level", int'(button_level), 0);
    reset = 1'b0;
    repeat (120) @(negedge clk);
    chk("reset_no_release", n_rel - br, 0);
    chk("reset_repress_latency", press_cyc - (r_edge + 1), 17);
    chk("reset_long_delay", long_cyc - press_cyc, 64);
    chk("reset_long_count", n_long - bl, 1);
    chk("reset_press_count", n_press - bp, 2);
    $display("phase reset_mid_press: reset_edge=%0d press_edge=%0d long_edge=%0d",
             r_edge, press_cyc, long_cyc);
    set_raw(1'b0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
